// File: rtl/avalon_st_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_pkg
// Description : Shared types and helpers for the Avalon-ST FIFO.
//               - pkt_state_t      : framing tracker states
//               - empty_width()    : width of the empty field, max(1, clog2)
//               - MAX_READY_LATENCY: largest supported sink ready latency
// Revision    : 1.0  initial release
// ============================================================================
package avalon_st_pkg;

  localparam int MAX_READY_LATENCY = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_t;

  // A one-symbol beat still carries a 1-bit empty field so the port never
  // collapses to zero width.
  function automatic int empty_width(input int symbols);
    return (symbols > 1) ? $clog2(symbols) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/avalon_st_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_fifo_if
// Description : Signal bundle for avalon_st_fifo.
//               Sink side  : snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i,
//                            snk_empty_i in; snk_ready_o out
//               Source side: src_data_o, src_valid_o, src_sop_o, src_eop_o,
//                            src_empty_o out; src_ready_i in
//               Status     : fill_level_o, almost_full_o, almost_empty_o,
//                            overflow_o, pkt_err_o out
//               modport slave  - the FIFO's view
//               modport master - the surrounding environment's view
// Revision    : 1.0  initial release
// ============================================================================
interface avalon_st_fifo_if
  import avalon_st_pkg::*;
#(
  parameter int SYMBOL_W = 8,
  parameter int SYMBOLS  = 4,
  parameter int ADDR_W   = 4
);

  localparam int DATA_W  = SYMBOL_W * SYMBOLS;
  localparam int EMPTY_W = empty_width(SYMBOLS);

  logic [DATA_W-1:0]  snk_data_i;
  logic               snk_valid_i;
  logic               snk_sop_i;
  logic               snk_eop_i;
  logic [EMPTY_W-1:0] snk_empty_i;
  logic               snk_ready_o;

  logic [DATA_W-1:0]  src_data_o;
  logic               src_valid_o;
  logic               src_sop_o;
  logic               src_eop_o;
  logic [EMPTY_W-1:0] src_empty_o;
  logic               src_ready_i;

  logic [ADDR_W:0]    fill_level_o;
  logic               almost_full_o;
  logic               almost_empty_o;
  logic               overflow_o;
  logic               pkt_err_o;

  modport slave (
    input  snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, snk_empty_i,
    output snk_ready_o,
    output src_data_o, src_valid_o, src_sop_o, src_eop_o, src_empty_o,
    input  src_ready_i,
    output fill_level_o, almost_full_o, almost_empty_o, overflow_o, pkt_err_o
  );

  modport master (
    output snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, snk_empty_i,
    input  snk_ready_o,
    input  src_data_o, src_valid_o, src_sop_o, src_eop_o, src_empty_o,
    output src_ready_i,
    input  fill_level_o, almost_full_o, almost_empty_o, overflow_o, pkt_err_o
  );

endinterface

`default_nettype wire

// File: rtl/avalon_st_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_fifo_ram
// Description : 2**ADDR_W x WIDTH storage array, registered write port and
//               asynchronous read port (show-ahead head for the FIFO).
//               clk_i   in  clock
//               wr_en   in  write strobe
//               wr_addr in  write address
//               wr_data in  write word
//               rd_addr in  read address
//               rd_data out word at rd_addr (combinational)
// Revision    : 1.0  initial release
// ============================================================================
module avalon_st_fifo_ram #(
  parameter int WIDTH  = 36,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage is deliberately not reset: the FIFO pointers define validity,
  // so stale words are never presented.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/avalon_st_fifo.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_fifo
// Description : Single-clock Avalon-ST FIFO. The sink port accepts beats with
//               a configurable ready latency; the source port presents the
//               head beat show-ahead (ready latency 0). Optional packet
//               sideband storage with framing-error detection, fill level,
//               almost-full / almost-empty flags and an overflow pulse.
//               clk_i  in  clock, rising edge
//               rst_i  in  asynchronous active-high reset
//               bus    avalon_st_fifo_if.slave - all stream and status signals
// Revision    : 1.0  initial release
// ============================================================================
module avalon_st_fifo
  import avalon_st_pkg::*;
#(
  parameter int SYMBOL_W      = 8,
  parameter int SYMBOLS       = 4,
  parameter int ADDR_W        = 4,
  parameter int READY_LATENCY = 1,
  parameter int USE_PACKETS   = 1,
  parameter int ALMOST_FULL   = 12,
  parameter int ALMOST_EMPTY  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  avalon_st_fifo_if.slave  bus
);

  localparam int DATA_W  = SYMBOL_W * SYMBOLS;
  localparam int EMPTY_W = empty_width(SYMBOLS);
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int ENTRY_W = DATA_W + 2 + EMPTY_W;
  localparam int LVL_W   = ADDR_W + 1;

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (READY_LATENCY < 0 || READY_LATENCY > MAX_READY_LATENCY) begin : g_chk_rl_range
    $error("avalon_st_fifo: READY_LATENCY must be 0..%0d", MAX_READY_LATENCY);
  end
  if (READY_LATENCY >= DEPTH) begin : g_chk_rl_depth
    $error("avalon_st_fifo: READY_LATENCY must be smaller than the depth");
  end
  if (ADDR_W < 1) begin : g_chk_addr
    $error("avalon_st_fifo: ADDR_W must be at least 1");
  end
  if (ALMOST_FULL < 0 || ALMOST_FULL > DEPTH) begin : g_chk_af
    $error("avalon_st_fifo: ALMOST_FULL must be 0..DEPTH");
  end
  if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH) begin : g_chk_ae
    $error("avalon_st_fifo: ALMOST_EMPTY must be 0..DEPTH");
  end

  // --------------------------------------------------------------------------
  // Pointers, level and handshake qualification
  // --------------------------------------------------------------------------
  logic [LVL_W-1:0]   wr_ptr;
  logic [LVL_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   space;
  logic               ready_en;
  logic               full;
  logic               not_empty;
  logic               snk_ready;
  logic               wr_cand;
  logic               wr_en;
  logic               drop;
  logic               rd_en;
  logic               overflow;

  logic               sop_in;
  logic               eop_in;
  logic [EMPTY_W-1:0] empty_in;
  logic [ENTRY_W-1:0] wr_word;
  logic [ENTRY_W-1:0] rd_word;

  assign full      = (level == LVL_W'(DEPTH));
  assign not_empty = (level != '0);
  assign space     = LVL_W'(DEPTH) - level;

  // Ready only while the free space strictly exceeds the ready latency, so
  // every beat already in flight when ready falls still has a slot.
  assign snk_ready = ready_en && (space > LVL_W'(READY_LATENCY));

  // With zero latency the source may hold valid high while ready is low, so
  // valid only counts when ready is high in the same cycle. With non-zero
  // latency the source is trusted to honour the delayed ready.
  if (READY_LATENCY == 0) begin : g_rl_zero
    assign wr_cand = bus.snk_valid_i && snk_ready;
  end else begin : g_rl_delayed
    assign wr_cand = bus.snk_valid_i && ready_en;
  end

  // A beat arriving at full is dropped even if a read frees a slot on the
  // same edge; this keeps the accept decision independent of src_ready_i.
  assign wr_en = wr_cand && !full;
  assign drop  = wr_cand && full;
  assign rd_en = not_empty && bus.src_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready_en <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // ready_en lags reset release by one edge, which also masks any beat
      // presented during the first cycle out of reset.
      ready_en <= 1'b1;
      overflow <= drop;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  assign wr_word = {sop_in, eop_in, empty_in, bus.snk_data_i};

  avalon_st_fifo_ram #(
    .WIDTH  (ENTRY_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_word),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_word)
  );

  // --------------------------------------------------------------------------
  // Packet sideband and framing tracker
  // --------------------------------------------------------------------------
  if (USE_PACKETS != 0) begin : g_pkt
    pkt_state_t state;
    pkt_state_t state_nxt;
    logic       err_nxt;
    logic       pkt_err;

    assign sop_in   = bus.snk_sop_i;
    assign eop_in   = bus.snk_eop_i;
    assign empty_in = bus.snk_empty_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state   <= IDLE;
        pkt_err <= 1'b0;
      end else begin
        state   <= state_nxt;
        pkt_err <= err_nxt;
      end
    end

    // Only stored beats advance the tracker; a dropped beat never reaches
    // the downstream sink, so it cannot break its framing.
    always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      if (wr_en) begin
        case (state)
          IDLE: begin
            if (!sop_in) begin
              err_nxt = 1'b1;          // bare beat, kept but flagged
            end else if (!eop_in) begin
              state_nxt = IN_PKT;      // sop+eop is a one-beat packet
            end
          end
          IN_PKT: begin
            if (sop_in) begin
              err_nxt = 1'b1;          // missing eop before a new sop
              if (eop_in) begin
                state_nxt = IDLE;
              end
            end else if (eop_in) begin
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end

    assign bus.src_sop_o   = rd_word[ENTRY_W-1];
    assign bus.src_eop_o   = rd_word[ENTRY_W-2];
    assign bus.src_empty_o = rd_word[DATA_W +: EMPTY_W];
    assign bus.pkt_err_o   = pkt_err;
  end else begin : g_no_pkt
    logic unused_side;

    assign sop_in   = 1'b0;
    assign eop_in   = 1'b0;
    assign empty_in = '0;
    assign unused_side = ^{bus.snk_sop_i, bus.snk_eop_i, bus.snk_empty_i,
                           rd_word[ENTRY_W-1:DATA_W]};

    assign bus.src_sop_o   = 1'b0;
    assign bus.src_eop_o   = 1'b0;
    assign bus.src_empty_o = '0;
    assign bus.pkt_err_o   = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.snk_ready_o    = snk_ready;
  assign bus.src_data_o     = rd_word[DATA_W-1:0];
  assign bus.src_valid_o    = not_empty;
  assign bus.fill_level_o   = level;
  assign bus.almost_full_o  = (level >= LVL_W'(ALMOST_FULL));
  assign bus.almost_empty_o = (level <= LVL_W'(ALMOST_EMPTY));
  assign bus.overflow_o     = overflow;

endmodule

`default_nettype wire

// File: tb/tb_avalon_st_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_st_fifo
// Description : Self-checking bench for avalon_st_fifo. One instance with
//               READY_LATENCY=1 takes a vector table plus directed fill,
//               overflow, wrap and reset sequences; two further instances with
//               READY_LATENCY=0 and 3 are driven by bursting sources against
//               a queue scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_avalon_st_fifo;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  avalon_st_fifo_if #(.SYMBOL_W(8), .SYMBOLS(4), .ADDR_W(4)) bus  ();
  avalon_st_fifo_if #(.SYMBOL_W(8), .SYMBOLS(4), .ADDR_W(4)) bus0 ();
  avalon_st_fifo_if #(.SYMBOL_W(8), .SYMBOLS(4), .ADDR_W(4)) bus3 ();

  avalon_st_fifo #(.READY_LATENCY(1)) dut (
    .clk_i (clk), .rst_i (rst), .bus (bus)
  );
  avalon_st_fifo #(.READY_LATENCY(0)) dut_rl0 (
    .clk_i (clk), .rst_i (rst), .bus (bus0)
  );
  avalon_st_fifo #(.READY_LATENCY(3)) dut_rl3 (
    .clk_i (clk), .rst_i (rst), .bus (bus3)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_sop;
    logic        e_eop;
    logic [1:0]  e_emp;
    int          e_level;
    logic        e_perr;
  } vec_t;

  vec_t tbl [15];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        prev_rdy;
    int          sent;
    logic        saw15;
    logic        rdy15_high;
    logic        ovf_seen;
    logic [31:0] q0 [$];
    logic [31:0] q3 [$];
    logic [31:0] n0;
    logic [31:0] n3;
    logic [2:0]  hist3;
    int          err0, err3, ovf0, ovf3, max0, max3, reads0, reads3;
    logic        rdy;

    errors = 0;
    checks = 0;

    //                v      d         sop   eop   emp    rdy  | valid  data      sop   eop   emp  lvl perr
    tbl[0]  = '{1'b1, 32'hA1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b0, 2'd0, 1, 1'b0};
    tbl[1]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b0, 2'd0, 2, 1'b0};
    tbl[2]  = '{1'b1, 32'hA3, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b0, 2'd0, 3, 1'b0};
    tbl[3]  = '{1'b1, 32'hB1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b0, 2'd0, 4, 1'b1};
    tbl[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, 2'd0, 3, 1'b0};
    tbl[5]  = '{1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 32'hA3, 1'b0, 1'b1, 2'd2, 2, 1'b0};
    tbl[6]  = '{1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 32'hB1, 1'b0, 1'b0, 2'd0, 1, 1'b0};
    tbl[7]  = '{1'b1, 32'hC1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 32'hC1, 1'b1, 1'b1, 2'd3, 1, 1'b0};
    tbl[8]  = '{1'b1, 32'hD1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 32'hD1, 1'b1, 1'b0, 2'd0, 1, 1'b0};
    tbl[9]  = '{1'b1, 32'hD2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'hD1, 1'b1, 1'b0, 2'd0, 2, 1'b1};
    tbl[10] = '{1'b1, 32'hD3, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 32'hD1, 1'b1, 1'b0, 2'd0, 3, 1'b1};
    tbl[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 32'hD2, 1'b1, 1'b0, 2'd0, 2, 1'b0};
    tbl[12] = '{1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 32'hD3, 1'b1, 1'b1, 2'd1, 1, 1'b0};
    tbl[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 0, 1'b0};
    tbl[14] = '{1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 0, 1'b0};

    // ---------------- reset and release ----------------
    rst = 1'b1;
    bus.snk_valid_i  = 1'b1;
    bus.snk_data_i   = 32'hBAD00000;
    bus.snk_sop_i    = 1'b1;
    bus.snk_eop_i    = 1'b0;
    bus.snk_empty_i  = 2'd0;
    bus.src_ready_i  = 1'b0;
    bus0.snk_valid_i = 1'b0;
    bus0.snk_data_i  = 32'h0;
    bus0.snk_sop_i   = 1'b0;
    bus0.snk_eop_i   = 1'b0;
    bus0.snk_empty_i = 2'd0;
    bus0.src_ready_i = 1'b0;
    bus3.snk_valid_i = 1'b0;
    bus3.snk_data_i  = 32'h0;
    bus3.snk_sop_i   = 1'b0;
    bus3.snk_eop_i   = 1'b0;
    bus3.snk_empty_i = 2'd0;
    bus3.src_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_src_valid", bus.src_valid_o, 1'b0);
    chkn("rst_level", 32'(bus.fill_level_o), 32'd0);
    chk1("rst_almost_empty", bus.almost_empty_o, 1'b1);
    chk1("rst_almost_full", bus.almost_full_o, 1'b0);
    chk1("rst_snk_ready", bus.snk_ready_o, 1'b0);
    chk1("rst_overflow", bus.overflow_o, 1'b0);
    chk1("rst_pkt_err", bus.pkt_err_o, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("release_ready_before_edge", bus.snk_ready_o, 1'b0);
    @(posedge clk);
    #1;
    chkn("release_beat_ignored", 32'(bus.fill_level_o), 32'd0);
    chk1("release_no_overflow", bus.overflow_o, 1'b0);
    chk1("release_ready_after_edge", bus.snk_ready_o, 1'b1);
    bus.snk_valid_i = 1'b0;
    bus.snk_sop_i   = 1'b0;

    // ---------------- vector table ----------------
    for (int i = 0; i < 15; i++) begin
      bus.snk_valid_i = tbl[i].v;
      bus.snk_data_i  = tbl[i].d;
      bus.snk_sop_i   = tbl[i].sop;
      bus.snk_eop_i   = tbl[i].eop;
      bus.snk_empty_i = tbl[i].emp;
      bus.src_ready_i = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk1($sformatf("tbl%0d_valid", i), bus.src_valid_o, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chkn($sformatf("tbl%0d_data", i), bus.src_data_o, tbl[i].e_data);
        chk1($sformatf("tbl%0d_sop", i), bus.src_sop_o, tbl[i].e_sop);
        chk1($sformatf("tbl%0d_eop", i), bus.src_eop_o, tbl[i].e_eop);
        chkn($sformatf("tbl%0d_empty", i), 32'(bus.src_empty_o), 32'(tbl[i].e_emp));
      end
      chkn($sformatf("tbl%0d_level", i), 32'(bus.fill_level_o), 32'(tbl[i].e_level));
      chk1($sformatf("tbl%0d_pkt_err", i), bus.pkt_err_o, tbl[i].e_perr);
      chk1($sformatf("tbl%0d_overflow", i), bus.overflow_o, 1'b0);
      chk1($sformatf("tbl%0d_ae", i), bus.almost_empty_o, tbl[i].e_level <= 2);
      chk1($sformatf("tbl%0d_snk_ready", i), bus.snk_ready_o, 1'b1);
    end
    bus.snk_valid_i = 1'b0;
    bus.snk_sop_i   = 1'b0;
    bus.snk_eop_i   = 1'b0;
    bus.snk_empty_i = 2'd0;
    bus.src_ready_i = 1'b0;

    // ---------------- fill 16 beats honouring ready latency 1 ----------------
    sent       = 0;
    saw15      = 1'b0;
    rdy15_high = 1'b0;
    ovf_seen   = 1'b0;
    prev_rdy   = bus.snk_ready_o;
    for (int cyc = 0; cyc < 60 && sent < 16; cyc++) begin
      bus.snk_valid_i = prev_rdy;
      bus.snk_data_i  = 32'(sent + 1);
      @(negedge clk);
      prev_rdy = bus.snk_ready_o;
      if (bus.fill_level_o == 5'd15) begin
        saw15 = 1'b1;
        if (bus.snk_ready_o) rdy15_high = 1'b1;
      end
      @(posedge clk);
      #1;
      if (bus.overflow_o) ovf_seen = 1'b1;
      if (bus.snk_valid_i) sent++;
    end
    bus.snk_valid_i = 1'b0;
    chkn("fill_beats_sent", 32'(sent), 32'd16);
    chk1("fill_saw_level15", saw15, 1'b1);
    chk1("fill_ready_at_15", rdy15_high, 1'b0);
    chk1("fill_no_overflow", ovf_seen, 1'b0);
    chkn("fill_level", 32'(bus.fill_level_o), 32'd16);
    chk1("fill_almost_full", bus.almost_full_o, 1'b1);
    chk1("fill_almost_empty", bus.almost_empty_o, 1'b0);
    chk1("fill_ready_full", bus.snk_ready_o, 1'b0);
    chkn("fill_head", bus.src_data_o, 32'h1);

    // ---------------- overflow with simultaneous read ----------------
    bus.snk_valid_i = 1'b1;
    bus.snk_data_i  = 32'hDEADBEEF;
    bus.src_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.snk_valid_i = 1'b0;
    bus.src_ready_i = 1'b0;
    chk1("ovf_pulse", bus.overflow_o, 1'b1);
    chkn("ovf_level", 32'(bus.fill_level_o), 32'd15);
    @(posedge clk);
    #1;
    chk1("ovf_pulse_once", bus.overflow_o, 1'b0);
    chkn("ovf_level_hold", 32'(bus.fill_level_o), 32'd15);
    for (int k = 2; k <= 16; k++) begin
      chkn($sformatf("drain_head%0d", k), bus.src_data_o, 32'(k));
      bus.src_ready_i = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.src_ready_i = 1'b0;
    chk1("drain_valid", bus.src_valid_o, 1'b0);
    chkn("drain_level", 32'(bus.fill_level_o), 32'd0);

    // ---------------- alternate write / read, pointer wrap ----------------
    for (int k = 0; k < 40; k++) begin
      bus.snk_valid_i = 1'b1;
      bus.snk_data_i  = 32'h100 + 32'(k);
      @(posedge clk);
      #1;
      bus.snk_valid_i = 1'b0;
      chkn($sformatf("wrap%0d_head", k), bus.src_data_o, 32'h100 + 32'(k));
      chkn($sformatf("wrap%0d_level_w", k), 32'(bus.fill_level_o), 32'd1);
      bus.src_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.src_ready_i = 1'b0;
      chkn($sformatf("wrap%0d_level_r", k), 32'(bus.fill_level_o), 32'd0);
    end

    // ---------------- asynchronous reset mid-stream ----------------
    for (int k = 0; k < 7; k++) begin
      bus.snk_valid_i = 1'b1;
      bus.snk_data_i  = 32'h200 + 32'(k);
      @(posedge clk);
      #1;
    end
    bus.snk_valid_i = 1'b0;
    chkn("midrst_level_before", 32'(bus.fill_level_o), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk1("midrst_src_valid", bus.src_valid_o, 1'b0);
    chkn("midrst_level", 32'(bus.fill_level_o), 32'd0);
    chk1("midrst_almost_empty", bus.almost_empty_o, 1'b1);
    chk1("midrst_snk_ready", bus.snk_ready_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("midrst_ready_after", bus.snk_ready_o, 1'b1);
    chk1("midrst_valid_after", bus.src_valid_o, 1'b0);

    // ---------------- ready latency 0 and 3 against bursting sources ----------------
    n0 = 32'h1000;
    n3 = 32'h3000;
    hist3 = 3'b000;
    err0 = 0; err3 = 0; ovf0 = 0; ovf3 = 0;
    max0 = 0; max3 = 0; reads0 = 0; reads3 = 0;
    bus0.snk_valid_i = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rdy = (cyc >= 200) || (cyc % 3 == 0);
      bus0.snk_data_i  = n0;
      bus0.src_ready_i = rdy;
      bus3.snk_valid_i = hist3[2];
      bus3.snk_data_i  = n3;
      bus3.src_ready_i = rdy;
      @(negedge clk);
      if (int'(bus0.fill_level_o) != q0.size()) err0++;
      if (int'(bus3.fill_level_o) != q3.size()) err3++;
      if (int'(bus0.fill_level_o) > max0) max0 = int'(bus0.fill_level_o);
      if (int'(bus3.fill_level_o) > max3) max3 = int'(bus3.fill_level_o);
      if (bus0.src_valid_o && rdy) begin
        if (q0.size() == 0 || bus0.src_data_o !== q0[0]) err0++;
        if (q0.size() != 0) void'(q0.pop_front());
        reads0++;
      end
      if (bus3.src_valid_o && rdy) begin
        if (q3.size() == 0 || bus3.src_data_o !== q3[0]) err3++;
        if (q3.size() != 0) void'(q3.pop_front());
        reads3++;
      end
      if (bus0.snk_ready_o) begin
        q0.push_back(n0);
        n0 = n0 + 32'd1;
      end
      if (bus3.snk_valid_i) begin
        q3.push_back(n3);
        n3 = n3 + 32'd1;
      end
      hist3 = {hist3[1:0], bus3.snk_ready_o};
      @(posedge clk);
      #1;
      if (bus0.overflow_o) ovf0++;
      if (bus3.overflow_o) ovf3++;
    end
    bus0.snk_valid_i = 1'b0;
    bus3.snk_valid_i = 1'b0;
    chkn("rl0_overflows", 32'(ovf0), 32'd0);
    chkn("rl3_overflows", 32'(ovf3), 32'd0);
    chkn("rl0_scoreboard_errors", 32'(err0), 32'd0);
    chkn("rl3_scoreboard_errors", 32'(err3), 32'd0);
    chkn("rl0_max_level", 32'(max0), 32'd16);
    chk1("rl3_max_level_reached", max3 >= 13, 1'b1);
    chk1("rl3_max_level_not_full", max3 <= 15, 1'b1);
    chk1("rl0_reads_seen", reads0 > 50, 1'b1);
    chk1("rl3_reads_seen", reads3 > 50, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
